// File: rtl/lift_pkg.sv
// Shared types and default sizing for the lift request scheduler.
package lift_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        EMERGENCY
    } lift_state_e;

    localparam int LIFT_NUM_FLOORS  = 4;
    localparam int LIFT_FLOOR_W     = 2;
    localparam int LIFT_DOOR_CYCLES = 4;

endpackage

// File: rtl/lift_req_mask.sv
// Pending floor-request register plus the above/below/here reductions
// relative to the floor the car currently reports.
module lift_req_mask
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = LIFT_NUM_FLOORS,
    parameter int FLOOR_W    = LIFT_FLOOR_W
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [NUM_FLOORS-1:0] floor_req_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    input  logic                  clear_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  above_o,
    output logic                  below_o,
    output logic                  here_o
);

    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic [NUM_FLOORS-1:0] cur_mask;

    assign cur_mask  = NUM_FLOORS'(1) << current_floor_i;
    // A request for the floor being served in the clearing cycle is absorbed.
    assign pending_d = (pending_q | floor_req_i) & ~(clear_i ? cur_mask : '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > current_floor_i) above_o = above_o | pending_q[i];
            if (FLOOR_W'(i) < current_floor_i) below_o = below_o | pending_q[i];
        end
    end

    assign here_o    = pending_q[current_floor_i] | floor_req_i[current_floor_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/lift_request_scheduler.sv
// SCAN (collective) lift scheduler: latches floor requests, sequences
// up/down motion and door dwell, and freezes on emergency stop.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS  = LIFT_NUM_FLOORS,
    parameter int FLOOR_W     = LIFT_FLOOR_W,
    parameter int DOOR_CYCLES = LIFT_DOOR_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [NUM_FLOORS-1:0] floor_req_i,
    input  logic                  emergency_stop_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    input  logic                  floor_arrived_i,
    output logic                  move_up_o,
    output logic                  move_down_o,
    output logic                  door_open_o,
    output logic                  dir_up_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

    lift_state_e      state_q, state_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             move_up_q, move_down_q, door_open_q;
    logic             door_load;
    logic             above, below, here;
    logic             at_top, at_bottom;

    lift_req_mask #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_mask (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .floor_req_i     (floor_req_i),
        .current_floor_i (current_floor_i),
        .clear_i         (door_load),
        .pending_o       (pending_o),
        .above_o         (above),
        .below_o         (below),
        .here_o          (here)
    );

    assign at_top    = (current_floor_i == FLOOR_W'(NUM_FLOORS - 1));
    assign at_bottom = (current_floor_i == '0);

    always_comb begin
        state_d   = state_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        door_load = 1'b0;
        if (emergency_stop_i) begin
            state_d = EMERGENCY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (here) begin
                        state_d   = DOOR_OPEN;
                        door_load = 1'b1;
                    end else if (above) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (below) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (floor_arrived_i) begin
                        if (pending_o[current_floor_i]) begin
                            state_d   = DOOR_OPEN;
                            door_load = 1'b1;
                        end else if (!above && at_top) begin
                            state_d = IDLE;
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (floor_arrived_i) begin
                        if (pending_o[current_floor_i]) begin
                            state_d   = DOOR_OPEN;
                            door_load = 1'b1;
                        end else if (!below && at_bottom) begin
                            state_d = IDLE;
                        end
                    end
                end
                DOOR_OPEN: begin
                    // A fresh call for this floor restarts the dwell instead of queueing.
                    if (floor_req_i[current_floor_i]) begin
                        door_load = 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        if (dir_up_q && above) begin
                            state_d = MOVE_UP;
                        end else if (!dir_up_q && below) begin
                            state_d = MOVE_DOWN;
                        end else if (dir_up_q && below) begin
                            state_d  = MOVE_DOWN;
                            dir_up_d = 1'b0;
                        end else if (!dir_up_q && above) begin
                            state_d  = MOVE_UP;
                            dir_up_d = 1'b1;
                        end
                    end
                end
                EMERGENCY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (door_load) cnt_d = CNT_W'(DOOR_CYCLES - 1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            dir_up_q    <= 1'b1;
            cnt_q       <= '0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_up_q    <= dir_up_d;
            cnt_q       <= cnt_d;
            move_up_q   <= (state_d == MOVE_UP);
            move_down_q <= (state_d == MOVE_DOWN);
            door_open_q <= (state_d == DOOR_OPEN);
        end
    end

    assign move_up_o   = move_up_q;
    assign move_down_o = move_down_q;
    assign door_open_o = door_open_q;
    assign dir_up_o    = dir_up_q;
    assign busy_o      = (state_q != IDLE);

    a_cmd_exclusive: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0({move_up_q, move_down_q, door_open_q}));

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Directed, table-driven bench for lift_request_scheduler with hand-written
// sequences for door re-arm, emergency stop and asynchronous reset.
module tb_lift_request_scheduler;

    logic       clk;
    logic       resetN;
    logic [3:0] floorReq;
    logic       emergencyStop;
    logic [1:0] currentFloor;
    logic       floorArrived;
    logic       moveUp, moveDown, doorOpen, dirUp, busy;
    logic [3:0] pending;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [3:0] req;
        logic [1:0] cur;
        logic       arr;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    lift_request_scheduler dut (
        .clk_i            (clk),
        .reset_n_i        (resetN),
        .floor_req_i      (floorReq),
        .emergency_stop_i (emergencyStop),
        .current_floor_i  (currentFloor),
        .floor_arrived_i  (floorArrived),
        .move_up_o        (moveUp),
        .move_down_o      (moveDown),
        .door_open_o      (doorOpen),
        .dir_up_o         (dirUp),
        .pending_o        (pending),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bundle layout: {up, down, door, dir, busy, pending[3:0]}
    function automatic logic [8:0] E(input logic up, input logic dn, input logic door,
                                     input logic dir, input logic bsy, input logic [3:0] pend);
        return {up, dn, door, dir, bsy, pend};
    endfunction

    function automatic vec_t V(input logic [3:0] req, input logic [1:0] cur, input logic arr,
                               input logic [8:0] exp);
        vec_t v;
        v.req = req;
        v.cur = cur;
        v.arr = arr;
        v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input logic [3:0] req, input logic estop,
                                 input logic [1:0] cur, input logic arr);
        floorReq      = req;
        emergencyStop = estop;
        currentFloor  = cur;
        floorArrived  = arr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] expected);
        logic [8:0] actual;
        actual = {moveUp, moveDown, doorOpen, dirUp, busy, pending};
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got {up,dn,door,dir,busy,pend}=%09b, expected %09b",
                     name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            nChecks++;
            if (!$onehot0({moveUp, moveDown, doorOpen})) begin
                nFails++;
                $display("[TB] FAIL cmd_exclusive: got up=%b dn=%b door=%b, expected at most one high",
                         moveUp, moveDown, doorOpen);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Scenario 1: idle at floor 0, call floor 2, travel up and dwell.
        vecs.push_back(V(4'b0100, 2'd0, 1'b0, E(0,0,0,1,0,4'b0100)));
        vecs.push_back(V(4'b0000, 2'd0, 1'b0, E(1,0,0,1,1,4'b0100)));
        vecs.push_back(V(4'b0000, 2'd1, 1'b1, E(1,0,0,1,1,4'b0100)));
        vecs.push_back(V(4'b0000, 2'd2, 1'b0, E(1,0,0,1,1,4'b0100)));
        vecs.push_back(V(4'b0000, 2'd2, 1'b1, E(0,0,1,1,1,4'b0000)));
        for (int i = 0; i < 3; i++) vecs.push_back(V(4'b0000, 2'd2, 1'b0, E(0,0,1,1,1,4'b0000)));
        vecs.push_back(V(4'b0000, 2'd2, 1'b0, E(0,0,0,1,0,4'b0000)));
        // Scenario 2: from floor 2 call floor 0, pass floor 1 without stopping.
        vecs.push_back(V(4'b0001, 2'd2, 1'b0, E(0,0,0,1,0,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd2, 1'b0, E(0,1,0,0,1,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd1, 1'b1, E(0,1,0,0,1,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd0, 1'b1, E(0,0,1,0,1,4'b0000)));
        for (int i = 0; i < 3; i++) vecs.push_back(V(4'b0000, 2'd0, 1'b0, E(0,0,1,0,1,4'b0000)));
        vecs.push_back(V(4'b0000, 2'd0, 1'b0, E(0,0,0,0,0,4'b0000)));
        // Scenario 3: SCAN order 1, 3, then reverse to 0.
        vecs.push_back(V(4'b1010, 2'd0, 1'b0, E(0,0,0,0,0,4'b1010)));
        vecs.push_back(V(4'b0000, 2'd0, 1'b0, E(1,0,0,1,1,4'b1010)));
        vecs.push_back(V(4'b0001, 2'd1, 1'b1, E(0,0,1,1,1,4'b1001)));
        for (int i = 0; i < 3; i++) vecs.push_back(V(4'b0000, 2'd1, 1'b0, E(0,0,1,1,1,4'b1001)));
        vecs.push_back(V(4'b0000, 2'd1, 1'b0, E(1,0,0,1,1,4'b1001)));
        vecs.push_back(V(4'b0000, 2'd2, 1'b1, E(1,0,0,1,1,4'b1001)));
        vecs.push_back(V(4'b0000, 2'd3, 1'b1, E(0,0,1,1,1,4'b0001)));
        for (int i = 0; i < 3; i++) vecs.push_back(V(4'b0000, 2'd3, 1'b0, E(0,0,1,1,1,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd3, 1'b0, E(0,1,0,0,1,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd2, 1'b1, E(0,1,0,0,1,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd1, 1'b1, E(0,1,0,0,1,4'b0001)));
        vecs.push_back(V(4'b0000, 2'd0, 1'b1, E(0,0,1,0,1,4'b0000)));
        for (int i = 0; i < 3; i++) vecs.push_back(V(4'b0000, 2'd0, 1'b0, E(0,0,1,0,1,4'b0000)));
        vecs.push_back(V(4'b0000, 2'd0, 1'b0, E(0,0,0,0,0,4'b0000)));

        resetN        = 1'b0;
        floorReq      = '0;
        emergencyStop = 1'b0;
        currentFloor  = '0;
        floorArrived  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", E(0,0,0,1,0,4'b0000));
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, 1'b0, vecs[i].cur, vecs[i].arr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Door re-arm at floor 3: re-pulse while the counter sits at 1.
        applyStimulus(4'b1000, 1'b0, 2'd3, 1'b0);
        checkOutput("rearm_open", E(0,0,1,0,1,4'b0000));
        applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0);
        checkOutput("rearm_cnt2", E(0,0,1,0,1,4'b0000));
        applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0);
        checkOutput("rearm_cnt1", E(0,0,1,0,1,4'b0000));
        applyStimulus(4'b1000, 1'b0, 2'd3, 1'b0);
        checkOutput("rearm_pulse", E(0,0,1,0,1,4'b0000));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0);
            checkOutput($sformatf("rearm_hold%0d", i), E(0,0,1,0,1,4'b0000));
        end
        applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0);
        checkOutput("rearm_close", E(0,0,0,0,0,4'b0000));

        // Emergency stop while moving up; a request keeps accumulating.
        applyStimulus(4'b1000, 1'b0, 2'd0, 1'b0);
        checkOutput("emg_latch", E(0,0,0,0,0,4'b1000));
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0);
        checkOutput("emg_move", E(1,0,0,1,1,4'b1000));
        applyStimulus(4'b0000, 1'b0, 2'd1, 1'b1);
        checkOutput("emg_pass1", E(1,0,0,1,1,4'b1000));
        applyStimulus(4'b0001, 1'b1, 2'd1, 1'b0);
        checkOutput("emg_stop0", E(0,0,0,1,1,4'b1001));
        applyStimulus(4'b0000, 1'b1, 2'd1, 1'b0);
        checkOutput("emg_stop1", E(0,0,0,1,1,4'b1001));
        applyStimulus(4'b0000, 1'b1, 2'd1, 1'b1);
        checkOutput("emg_stop2", E(0,0,0,1,1,4'b1001));
        applyStimulus(4'b0000, 1'b0, 2'd1, 1'b0);
        checkOutput("emg_idle", E(0,0,0,1,0,4'b1001));
        applyStimulus(4'b0000, 1'b0, 2'd1, 1'b0);
        checkOutput("emg_resume", E(1,0,0,1,1,4'b1001));
        applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1);
        checkOutput("emg_arrive3", E(0,0,1,1,1,4'b0001));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0);
            checkOutput($sformatf("emg_door%0d", i), E(0,0,1,1,1,4'b0001));
        end
        applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0);
        checkOutput("emg_reverse", E(0,1,0,0,1,4'b0001));

        // Asynchronous reset mid-travel, well away from any clock edge.
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async_reset", E(0,0,0,1,0,4'b0000));
        #2;
        resetN = 1'b1;
        applyStimulus(4'b0000, 1'b0, 2'd2, 1'b0);
        checkOutput("post_reset", E(0,0,0,1,0,4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/lift_request_scheduler.md
Name: lift_request_scheduler

Overview:
- Request scheduler and sequencer that sits in front of the lift motor datapath.
- Latches floor-request pulses into a pending mask and picks direction using SCAN (collective): keep going while requests lie ahead, otherwise reverse.
- Drives move_up/move_down commands to the lift and times the door-open dwell.
- Handles emergency stop without losing pending requests.

Parameters:
- NUM_FLOORS, 4, number of floors; floors indexed 0..NUM_FLOORS-1.
- FLOOR_W, 2, width of floor index; must equal clog2(NUM_FLOORS).
- DOOR_CYCLES, 4, clock cycles door_open stays high per stop; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- floor_req  in  NUM_FLOORS  request pulses, bit i = floor i; OR-ed into pending each cycle.
- emergency_stop  in  1  level; while high, all motion and door commands are forced low.
- current_floor  in  FLOOR_W  floor reported by the lift datapath; valid every cycle.
- floor_arrived  in  1  one-cycle pulse from the datapath when the car reaches current_floor.
- move_up  out  1  command lift upward (registered).
- move_down  out  1  command lift downward (registered).
- door_open  out  1  door open at current_floor (registered).
- dir_up  out  1  last committed travel direction, 1 = up.
- pending  out  NUM_FLOORS  outstanding request mask.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; pending=0; move_up=move_down=door_open=0; dir_up=1; door counter=0; busy=0.
- Request latch: pending_next = (pending | floor_req) & ~clear_mask.
  - clear_mask = the current_floor bit in the cycle the FSM enters or re-arms DOOR_OPEN.
  - A floor_req bit for the current floor in that same cycle is absorbed, not set.
- Helpers (combinational): above = |pending bits > current_floor; below = |pending bits < current_floor; here = pending[current_floor] | floor_req[current_floor].
- IDLE:
  - here → DOOR_OPEN.
  - else above → MOVE_UP, dir_up=1.
  - else below → MOVE_DOWN, dir_up=0.
  - else stay.
- MOVE_UP: move_up=1 in the cycle after entry. On floor_arrived:
  - pending[current_floor] → DOOR_OPEN.
  - else, if no request above and current_floor=NUM_FLOORS-1 → IDLE.
  - else stay.
- MOVE_DOWN: mirror of MOVE_UP, with the stop boundary at floor 0.
- DOOR_OPEN:
  - door_open=1; counter loads DOOR_CYCLES-1 on entry and decrements to 0.
  - A new request for current_floor re-arms the counter and is not set in pending.
  - At counter=0, SCAN decision: dir_up & above → MOVE_UP; !dir_up & below → MOVE_DOWN; otherwise the opposite direction if it has requests (dir_up flips); otherwise IDLE.
- EMERGENCY:
  - Entered from any state when emergency_stop=1, with priority over all other transitions.
  - All commands 0; pending still accumulates; door counter cleared.
  - On emergency_stop falling → IDLE; the normal IDLE decision resumes next cycle.
- Mutual exclusion: move_up, move_down and door_open are never high together; a violation is an assertion failure.
- floor_arrived is ignored outside MOVE_UP/MOVE_DOWN.
- Latency:
  - Request at an idle non-current floor → motion command 2 cycles after the request pulse (latch, then decide).
  - Request at the current idle floor → door_open 1 cycle after the pulse.

Decomposition:
- Shared package lift_pkg:
  - state enum: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERGENCY.
  - NUM_FLOORS and FLOOR_W defaults.
  - DOOR_CYCLES default.
- One sub-module, lift_req_mask: pending register plus above/below/here reduction logic, parameterised by NUM_FLOORS.
- The FSM and door counter stay in the top module.

Test Plan:
- Reset, then floor 0, floor_req=0100 pulse → move_up=1 by cycle 2. At floor_arrived with current_floor=2 → door_open for 4 cycles, pending=0000, then IDLE.
- At floor 2, pulse 0001 → move_down; floor_arrived at floor 1 does not stop; stops at 0, door_open=1, pending clears.
- At floor 0 moving up with pending 1010, pulse floor_req=0001 at floor 1 → services 1 then 3 (dir_up held), then reverses to serve 0.
- In DOOR_OPEN at floor 3, re-pulse 1000 at counter=1 → door_open extends a full 4 cycles; pending[3] stays 0.
- In MOVE_UP, assert emergency_stop for 3 cycles while pulsing 0001 → all commands 0 and pending[0]=1. After release → IDLE, then motion resumes toward the remaining requests.
- Assert reset_n=0 mid-MOVE_DOWN, asynchronously (no clock edge) → move_down=0 and pending=0 immediately.
